// File: rtl/srv_icb_nv1_if.sv
// ----------------------------------------------------------------------------
// srv_icb_nv1_if
// ICB bundle carrying NUM parallel lanes of command/response signals.
// The arbiter uses one instance with NUM = number of upstream masters and a
// second instance with NUM = 1 for the merged downstream port.
//
//   cmd_valid/cmd_ready     per-lane command handshake
//   cmd_addr/cmd_read       command address, 1 = read / 0 = write
//   cmd_wdata/cmd_wmask     write data and byte mask
//   resp_valid/resp_ready   per-lane response handshake
//   resp_rdata/resp_err     response data and error flag
//
// Modports: master issues commands and accepts responses; slave the reverse.
// ----------------------------------------------------------------------------
interface srv_icb_nv1_if #(
  parameter int NUM    = 1,
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  localparam int W_MASK = W_DATA / 8;

  logic [NUM-1:0]             cmd_valid;
  logic [NUM-1:0]             cmd_ready;
  logic [NUM-1:0][W_ADDR-1:0] cmd_addr;
  logic [NUM-1:0]             cmd_read;
  logic [NUM-1:0][W_DATA-1:0] cmd_wdata;
  logic [NUM-1:0][W_MASK-1:0] cmd_wmask;
  logic [NUM-1:0]             resp_valid;
  logic [NUM-1:0]             resp_ready;
  logic [NUM-1:0][W_DATA-1:0] resp_rdata;
  logic [NUM-1:0]             resp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, resp_ready,
    input  cmd_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, resp_ready,
    output cmd_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/srv_icb_nv1.sv
// ----------------------------------------------------------------------------
// srv_icb_nv1
// N-to-1 ICB arbiter. Merges G_US_NUM upstream masters onto one downstream
// ICB port. Commands are granted round-robin; a grant that is stalled by the
// downstream side is locked until accepted so the payload stays stable.
// Every accepted command pushes its one-hot master index into an in-order
// tracking FIFO whose head routes the next response back to its issuer.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   active    high while any transaction is outstanding
//   us        upstream bundle (slave side, G_US_NUM lanes)
//   ds        downstream bundle (master side, 1 lane)
// ----------------------------------------------------------------------------
module srv_icb_nv1 #(
  parameter int G_US_NUM = 2,
  parameter int G_W_ADDR = 32,
  parameter int G_W_DATA = 32,
  parameter int G_MPX    = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  output logic           active,
  srv_icb_nv1_if.slave   us,
  srv_icb_nv1_if.master  ds
);

  localparam int W_MASK = G_W_DATA / 8;
  localparam int IDX_W  = $clog2(G_US_NUM);
  localparam int PTR_W  = (G_MPX > 1) ? $clog2(G_MPX) : 1;
  localparam int CNT_W  = $clog2(G_MPX + 1);

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  // First requester at or above ptr, wrapping modulo G_US_NUM.
  function automatic logic [G_US_NUM-1:0] rr_pick(
    input logic [G_US_NUM-1:0] req,
    input logic [IDX_W-1:0]    ptr
  );
    logic [G_US_NUM-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < G_US_NUM; k++) begin
      idx = int'(ptr) + k;
      if (idx >= G_US_NUM) idx = idx - G_US_NUM;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [G_US_NUM-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < G_US_NUM; i++) begin
      if (oh[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(G_MPX - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [IDX_W-1:0]    rr_ptr_q,   rr_ptr_d;
  logic                lock_q,     lock_d;
  logic [G_US_NUM-1:0] lock_gnt_q, lock_gnt_d;
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [G_US_NUM-1:0] fifo_q [G_MPX];

  // --------------------------------------------------------------------------
  // Command path
  // --------------------------------------------------------------------------
  logic [G_US_NUM-1:0] arb_gnt;
  logic [G_US_NUM-1:0] gnt;
  logic [IDX_W-1:0]    win_idx;
  logic                full;
  logic                empty;
  logic                cmd_hs;
  logic                resp_hs;

  assign arb_gnt = rr_pick(us.cmd_valid, rr_ptr_q);
  assign gnt     = lock_q ? lock_gnt_q : arb_gnt;
  assign win_idx = onehot_idx(gnt);
  assign full    = (cnt_q == CNT_W'(G_MPX));
  assign empty   = (cnt_q == '0);

  // Outputs are also qualified by reset_n so the port is quiet while reset is
  // held, not just after the first edge.
  assign ds.cmd_valid[0] = reset_n & (|(gnt & us.cmd_valid)) & ~full;
  assign us.cmd_ready    = gnt & {G_US_NUM{reset_n & ds.cmd_ready[0] & ~full}};
  assign cmd_hs          = ds.cmd_valid[0] & ds.cmd_ready[0];

  // Grant is one-hot or zero, so an AND-OR mux is sufficient and yields an
  // all-zero payload when nobody is granted.
  logic [G_W_ADDR-1:0] mux_addr;
  logic                mux_read;
  logic [G_W_DATA-1:0] mux_wdata;
  logic [W_MASK-1:0]   mux_wmask;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    mux_addr  = '0;
    mux_read  = 1'b0;
    mux_wdata = '0;
    mux_wmask = '0;
    for (int i = 0; i < G_US_NUM; i++) begin
      if (gnt[i]) begin
        mux_addr  = mux_addr  | us.cmd_addr[i];
        mux_read  = mux_read  | us.cmd_read[i];
        mux_wdata = mux_wdata | us.cmd_wdata[i];
        mux_wmask = mux_wmask | us.cmd_wmask[i];
      end
    end
  end

  assign ds.cmd_addr[0]  = mux_addr;
  assign ds.cmd_read[0]  = mux_read;
  assign ds.cmd_wdata[0] = mux_wdata;
  assign ds.cmd_wmask[0] = mux_wmask;

  // --------------------------------------------------------------------------
  // Response path
  // --------------------------------------------------------------------------
  logic [G_US_NUM-1:0] head;

  assign head             = empty ? '0 : fifo_q[rd_ptr_q];
  assign us.resp_valid    = head & {G_US_NUM{ds.resp_valid[0]}};
  assign ds.resp_ready[0] = |(head & us.resp_ready);
  assign us.resp_rdata    = {G_US_NUM{ds.resp_rdata[0]}};
  assign us.resp_err      = {G_US_NUM{ds.resp_err[0]}};
  assign resp_hs          = ds.resp_valid[0] & ds.resp_ready[0];

  assign active = ~empty;

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_gnt_d = lock_gnt_q;
    if (cmd_hs) begin
      rr_ptr_d = (win_idx == IDX_W'(G_US_NUM - 1)) ? '0 : win_idx + IDX_W'(1);
      lock_d   = 1'b0;
    end else if (ds.cmd_valid[0]) begin
      // Offered but not taken: freeze the grant. When full, ds.cmd_valid is
      // low and the lock simply keeps its current value.
      lock_d     = 1'b1;
      lock_gnt_d = gnt;
    end
  end

  always_comb begin
    wr_ptr_d = cmd_hs  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = resp_hs ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({cmd_hs, resp_hs})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_gnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_gnt_q <= lock_gnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: the tracking storage is not reset; an entry is only read once the
  // count says it was written, so resetting pointers and count is enough.
  always_ff @(posedge clk) begin
    if (cmd_hs) fifo_q[wr_ptr_q] <= gnt;
  end

  // A response with nothing outstanding has nowhere to go.
  resp_needs_entry: assert property (
    @(posedge clk) disable iff (!reset_n) ds.resp_valid[0] |-> !empty
  );

endmodule

// File: tb/tb_srv_icb_nv1.sv
// ----------------------------------------------------------------------------
// tb_srv_icb_nv1
// Self-checking bench for srv_icb_nv1 (2 masters, 2 outstanding). A reference
// model keeps the outstanding master indices in a queue, the round-robin
// pointer and the locked master as integers, and predicts every output each
// cycle. Directed scenarios are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_srv_icb_nv1;
  localparam int N   = 2;
  localparam int WA  = 32;
  localparam int WD  = 32;
  localparam int WM  = WD / 8;
  localparam int MPX = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic active;

  srv_icb_nv1_if #(.NUM(N), .W_ADDR(WA), .W_DATA(WD)) us_if ();
  srv_icb_nv1_if #(.NUM(1), .W_ADDR(WA), .W_DATA(WD)) ds_if ();

  srv_icb_nv1 #(
    .G_US_NUM(N), .G_W_ADDR(WA), .G_W_DATA(WD), .G_MPX(MPX)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .active  (active),
    .us      (us_if),
    .ds      (ds_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_rr;
  bit m_lock;
  int m_lock_idx;
  int m_q[$];
  int last_grant;

  task automatic model_reset();
    m_rr   = 0;
    m_lock = 0;
    m_lock_idx = 0;
    m_q.delete();
    last_grant = -1;
  endtask

  // Predicts and checks all outputs for the current inputs, then advances.
  task automatic eval_cycle();
    int g;
    int head;
    bit full;
    bit dsv;
    bit drr;
    logic [N-1:0]  e_rdy;
    logic [N-1:0]  e_rv;
    logic [WA-1:0] e_addr;
    logic          e_read;
    logic [WD-1:0] e_wdata;
    logic [WM-1:0] e_wmask;
    full = (m_q.size() == MPX);
    g = -1;
    if (m_lock) g = m_lock_idx;
    else
      for (int k = 0; k < N; k++)
        if (g < 0 && us_if.cmd_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    dsv     = (g >= 0) && us_if.cmd_valid[g] && !full;
    e_addr  = (g >= 0) ? us_if.cmd_addr[g]  : '0;
    e_read  = (g >= 0) ? us_if.cmd_read[g]  : 1'b0;
    e_wdata = (g >= 0) ? us_if.cmd_wdata[g] : '0;
    e_wmask = (g >= 0) ? us_if.cmd_wmask[g] : '0;
    e_rdy = '0;
    if (g >= 0 && ds_if.cmd_ready[0] && !full) e_rdy[g] = 1'b1;
    head = (m_q.size() > 0) ? m_q[0] : -1;
    e_rv = '0;
    if (head >= 0 && ds_if.resp_valid[0]) e_rv[head] = 1'b1;
    drr = (head >= 0) && us_if.resp_ready[head];

    check("ds_cmd_valid",  ds_if.cmd_valid[0], dsv);
    check("us_cmd_ready",  us_if.cmd_ready,    e_rdy);
    check("ds_cmd_addr",   ds_if.cmd_addr[0],  e_addr);
    check("ds_cmd_read",   ds_if.cmd_read[0],  e_read);
    check("ds_cmd_wdata",  ds_if.cmd_wdata[0], e_wdata);
    check("ds_cmd_wmask",  ds_if.cmd_wmask[0], e_wmask);
    check("us_resp_valid", us_if.resp_valid,   e_rv);
    check("ds_resp_ready", ds_if.resp_ready[0], drr);
    check("active",        active,             m_q.size() != 0);
    for (int i = 0; i < N; i++) begin
      check("us_resp_rdata", us_if.resp_rdata[i], ds_if.resp_rdata[0]);
      check("us_resp_err",   us_if.resp_err[i],   ds_if.resp_err[0]);
    end

    last_grant = (dsv && ds_if.cmd_ready[0]) ? g : -1;
    if (ds_if.resp_valid[0] && drr) void'(m_q.pop_front());
    if (dsv && ds_if.cmd_ready[0]) begin
      m_q.push_back(g);
      m_rr   = (g + 1) % N;
      m_lock = 0;
    end else if (dsv) begin
      m_lock     = 1;
      m_lock_idx = g;
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are compared at the
  // falling edge and the model advances with the next rising edge.
  task automatic step();
    @(negedge clk);
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_us(input logic [N-1:0] valid, input logic [N-1:0] read);
    us_if.cmd_valid = valid;
    us_if.cmd_read  = read;
  endtask

  task automatic set_resp(input logic vld, input logic [WD-1:0] rdata, input logic err,
                          input logic [N-1:0] rdy);
    ds_if.resp_valid[0] = vld;
    ds_if.resp_rdata[0] = rdata;
    ds_if.resp_err[0]   = err;
    us_if.resp_ready    = rdy;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int exp_order[4];
    exp_order = '{0, 1, 0, 1};
    reset_n = 1'b0;
    us_if.cmd_valid = '0;
    us_if.cmd_read  = '0;
    us_if.cmd_addr[0] = 32'h1000;
    us_if.cmd_addr[1] = 32'h2000;
    us_if.cmd_wdata[0] = 32'h0000_00A0;
    us_if.cmd_wdata[1] = 32'h0000_00B1;
    us_if.cmd_wmask[0] = 4'hF;
    us_if.cmd_wmask[1] = 4'h3;
    us_if.resp_ready = '0;
    ds_if.cmd_ready[0]  = 1'b0;
    ds_if.resp_valid[0] = 1'b0;
    ds_if.resp_rdata[0] = '0;
    ds_if.resp_err[0]   = 1'b0;
    model_reset();

    // Reset values
    #2;
    check("rst_active",   active, 0);
    check("rst_dsv",      ds_if.cmd_valid[0], 0);
    check("rst_drr",      ds_if.resp_ready[0], 0);
    check("rst_us_ready", us_if.cmd_ready, 0);
    check("rst_us_rv",    us_if.resp_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Round-robin order with both masters requesting, responses drained
    set_us(2'b11, 2'b11);
    ds_if.cmd_ready[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) set_resp(1'b1, 32'h1234_0000 + c, 1'b0, 2'b11);
      step();
      check("rr_order", last_grant, exp_order[c]);
    end
    set_us(2'b00, 2'b00);
    step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // Two outstanding, third command stalls
    set_us(2'b11, 2'b11);
    repeat (2) step();
    check("stall_active", active, 1);
    check("stall_dsv",    ds_if.cmd_valid[0], 0);
    step();
    set_us(2'b00, 2'b00);
    set_resp(1'b1, 32'h5, 1'b0, 2'b11);
    repeat (2) step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // Grant lock: master 1 stalled 3 cycles, master 0 joins in cycle 2
    us_if.cmd_addr[1] = 32'h100;
    ds_if.cmd_ready[0] = 1'b0;
    set_us(2'b10, 2'b10);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_us(2'b11, 2'b11);
      #1 check("lock_addr", ds_if.cmd_addr[0], 32'h100);
      step();
      check("lock_nogrant", last_grant, -1);
    end
    ds_if.cmd_ready[0] = 1'b1;
    step();
    check("lock_m1_first", last_grant, 1);
    step();
    check("lock_m0_next", last_grant, 0);
    set_us(2'b00, 2'b00);
    set_resp(1'b1, 32'h77, 1'b0, 2'b11);
    repeat (2) step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // Response routing: M0 read, then M1 write
    us_if.cmd_addr[0] = 32'h200;
    set_us(2'b01, 2'b01);
    step();
    set_us(2'b10, 2'b00);
    step();
    set_us(2'b00, 2'b00);
    set_resp(1'b1, 32'hAAAA_0000, 1'b0, 2'b11);
    #1 check("route_first", us_if.resp_valid, 2'b01);
    step();
    set_resp(1'b1, 32'h0, 1'b1, 2'b11);
    #1 check("route_second", us_if.resp_valid, 2'b10);
    check("route_err", us_if.resp_err, 2'b11);
    step();
    set_resp(1'b0, '0, 1'b0, 2'b00);
    #1 check("route_idle", active, 0);

    // Full: same-cycle pop does not unblock; push+pop keeps one outstanding
    set_us(2'b11, 2'b11);
    repeat (2) step();
    set_us(2'b01, 2'b01);
    set_resp(1'b1, 32'h11, 1'b0, 2'b11);
    #1 check("full_gate", ds_if.cmd_valid[0], 0);
    step();
    #1 check("full_next", ds_if.cmd_valid[0], 1);
    step();
    set_us(2'b00, 2'b00);
    #1 check("pushpop_active", active, 1);
    check("pushpop_head", us_if.resp_valid, 2'b01);
    step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // M0 back-pressures its response for 4 cycles
    set_us(2'b01, 2'b01);
    step();
    set_us(2'b00, 2'b00);
    set_resp(1'b1, 32'h99, 1'b0, 2'b00);
    for (int c = 0; c < 4; c++) begin
      #1 check("bp_drr", ds_if.resp_ready[0], 0);
      check("bp_rv1", us_if.resp_valid[1], 0);
      step();
    end
    set_resp(1'b1, 32'h99, 1'b0, 2'b01);
    step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // Reset with two outstanding
    set_us(2'b11, 2'b11);
    repeat (2) step();
    ds_if.resp_valid[0] = 1'b1;
    reset_n = 1'b0;
    #1;
    check("mrst_active", active, 0);
    check("mrst_dsv",    ds_if.cmd_valid[0], 0);
    check("mrst_rv",     us_if.resp_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    ds_if.resp_valid[0] = 1'b0;
    reset_n = 1'b1;
    #1 check("post_rst_gnt", us_if.cmd_ready, 2'b01);
    step();
    set_us(2'b00, 2'b00);
    set_resp(1'b1, 32'h3, 1'b0, 2'b11);
    step();
    set_resp(1'b0, '0, 1'b0, 2'b00);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      us_if.cmd_valid = N'($urandom);
      us_if.cmd_read  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        us_if.cmd_addr[i]  = $urandom;
        us_if.cmd_wdata[i] = $urandom;
        us_if.cmd_wmask[i] = WM'($urandom);
      end
      ds_if.cmd_ready[0]  = ($urandom_range(0, 9) < 7);
      ds_if.resp_valid[0] = (m_q.size() > 0) && ($urandom_range(0, 9) < 6);
      ds_if.resp_rdata[0] = $urandom;
      ds_if.resp_err[0]   = 1'($urandom);
      us_if.resp_ready    = N'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
